jtdd_scr_romrq: RTL and testbench
=================================

JTDD_SCR_ROMRQ -- requirements
Module: jtdd_scr_romrq

Interface
REQ-001 Parameter OFFSET, default 22'h0, SDRAM word base address of the scroll tile ROM region.
REQ-002 Parameter AW, default 17, width of the tile ROM word address.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 addr  input  AW  tile ROM word address from the scroll layer.
REQ-006 addr_ok  input  1  addr is valid this cycle.
REQ-007 dout  output  16  tile ROM word for the cached address.
REQ-008 data_ok  output  1  dout is valid for the current addr.
REQ-009 sdram_addr  output  22  SDRAM word address.
REQ-010 sdram_req  output  1  SDRAM read request, level.
REQ-011 sdram_ack  input  1  one-cycle pulse: request accepted.
REQ-012 data_read  input  1  one-cycle pulse: sdram_din valid.
REQ-013 sdram_din  input  16  SDRAM read data.

Function
REQ-014 The block SHALL hold a cache line: tag (AW bits), valid bit, data (16 bits).
REQ-015 Hit: addr_ok=1, valid=1 and addr==tag; dout SHALL be the line data and data_ok SHALL be 1 in the same cycle (combinational compare, registered line).
REQ-016 data_ok SHALL be 0 whenever addr_ok=0 or the access misses.
REQ-017 The FSM SHALL have the states IDLE, REQ and WAIT.
REQ-018 IDLE: on a miss, the block SHALL latch addr into the pending register, drive sdram_req=1 from the next cycle and go to REQ.
REQ-019 sdram_addr SHALL be OFFSET + zero-extended pending address, modulo 2^22 (wraps silently).
REQ-020 REQ: sdram_req SHALL stay 1 and sdram_addr stable until sdram_ack; on sdram_ack, sdram_req SHALL drop in the next cycle and the FSM SHALL go to WAIT.
REQ-021 WAIT: on data_read, the block SHALL write sdram_din into the line, set the tag to the pending address and set valid=1, then go to IDLE.
REQ-022 sdram_ack and data_read in the same cycle while in REQ: both SHALL be accepted, the line written and the FSM SHALL go directly to IDLE.
REQ-023 An addr change during REQ/WAIT SHALL NOT abort the fetch; the fetch completes and the new addr is compared in IDLE (a miss starts a new fetch on the cycle after the return to IDLE).
REQ-024 data_read outside WAIT (and outside the REQ case in REQ-022) SHALL be ignored.
REQ-025 Miss-to-data_ok latency SHALL be 3 clk plus the SDRAM ack and data latencies.

Reset
REQ-026 On rst: FSM=IDLE, valid=0, tag=0, line data=0, pending=0, sdram_req=0; dout=0 and data_ok=0 follow.
REQ-027 An rst asserted mid-fetch SHALL abandon the fetch; any later data_read SHALL be ignored.

Configuration
REQ-028 Macro JTDD_SCR_DUALLINE_EN defined: two cache lines with LRU replacement (the hit line becomes MRU, a fill replaces the LRU line), and a hit on either line satisfies REQ-015.
REQ-029 Macro JTDD_SCR_DUALLINE_EN undefined: a single line exactly as in REQ-014..REQ-024.

Structure
REQ-030 A shared package jtdd_pkg SHALL hold the FSM state encoding (IDLE=0, REQ=1, WAIT=2) and the 22-bit SDRAM address width constant.
REQ-031 One sub-module, jtdd_romrq_line, SHALL implement a tag/valid/data line with compare output; it is instantiated once or twice per REQ-028/029.

Verification
REQ-032 After reset, addr=17'h00010 with addr_ok=1 -> data_ok=0; sdram_req=1 one cycle later with sdram_addr=22'h000010 (OFFSET=0).
REQ-033 ack after 2 cycles, data_read with sdram_din=16'hA55A 3 cycles after that -> data_ok=1, dout=16'hA55A; addr held, no further sdram_req.
REQ-034 OFFSET=22'h3F0000, addr=17'h1FFFF -> sdram_addr=22'h00FFFF (wrap).
REQ-035 addr changes from 17'h00010 to 17'h00020 while in WAIT -> the 0x10 line is filled, data_ok stays 0, and a second request with sdram_addr=22'h000020 follows.
REQ-036 Same-cycle ack and data_read -> line filled, FSM in IDLE next cycle, data_ok=1.
REQ-037 rst pulsed in WAIT, then data_read -> valid=0, data_ok=0, sdram_req=0; with JTDD_SCR_DUALLINE_EN, alternating 0x10/0x20 after both fills -> no new sdram_req.

Source files
------------

// File: rtl/jtdd_pkg.sv
// Shared definitions for the scroll tile ROM request path:
// the FSM state encoding and the SDRAM word address width.
package jtdd_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } romrq_state_t;

endpackage

// File: rtl/jtdd_romrq_line.sv
// One cache line holding a tag, a valid bit and a 16-bit data word.
// The compare against the incoming address is combinational.
module jtdd_romrq_line #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [15:0]   wr_data,
  output logic          hit,
  output logic [15:0]   data
);

  logic [AW-1:0] tag;
  logic          valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      valid <= 1'b0;
      data  <= 16'h0;
    end else if (wr) begin
      tag   <= wr_tag;
      valid <= 1'b1;
      data  <= wr_data;
    end
  end

  assign hit = valid && (addr == tag);

endmodule

// File: rtl/jtdd_scr_romrq.sv
// Scroll tile ROM request cache: serves hits from a cached line and fetches
// misses over the SDRAM port. Define JTDD_SCR_DUALLINE_EN for two LRU lines.
module jtdd_scr_romrq
  import jtdd_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
  parameter int                  AW     = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       addr,
  input  logic                addr_ok,
  output logic [15:0]         dout,
  output logic                data_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_read,
  input  logic [15:0]         sdram_din
);

  romrq_state_t  state;
  logic [AW-1:0] pending;
  logic          hit;
  logic [15:0]   line_data;
  logic          fill;

  // A data_read in REQ only counts when it arrives together with the ack.
  assign fill = ((state == ST_WAIT) && data_read) ||
                ((state == ST_REQ) && sdram_ack && data_read);

`ifdef JTDD_SCR_DUALLINE_EN
  logic        hit0, hit1;
  logic [15:0] data0, data1;
  logic        lru;

  jtdd_romrq_line #(.AW(AW)) u_line0 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (fill && !lru),
    .wr_tag  (pending),
    .wr_data (sdram_din),
    .hit     (hit0),
    .data    (data0)
  );

  jtdd_romrq_line #(.AW(AW)) u_line1 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (fill && lru),
    .wr_tag  (pending),
    .wr_data (sdram_din),
    .hit     (hit1),
    .data    (data1)
  );

  // lru names the line to replace next; a fill makes the written line MRU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru <= 1'b0;
    end else if (fill) begin
      lru <= ~lru;
    end else if (addr_ok && hit0) begin
      lru <= 1'b1;
    end else if (addr_ok && hit1) begin
      lru <= 1'b0;
    end
  end

  assign hit       = hit0 || hit1;
  assign line_data = hit1 ? data1 : data0;
`else
  jtdd_romrq_line #(.AW(AW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (fill),
    .wr_tag  (pending),
    .wr_data (sdram_din),
    .hit     (hit),
    .data    (line_data)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= '0;
      sdram_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (addr_ok && !hit) begin
            pending   <= addr;
            sdram_req <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= data_read ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_read) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

  assign sdram_addr = OFFSET + {{(SDRAM_AW-AW){1'b0}}, pending};
  assign dout       = line_data;
  assign data_ok    = addr_ok && hit;

endmodule

// File: tb/tb_jtdd_scr_romrq.sv
// Directed bench for jtdd_scr_romrq: fetch, wrap, addr change mid-fetch,
// same-cycle ack/data and reset mid-fetch, with hand-computed expectations.
module tb_jtdd_scr_romrq;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] addr;
  logic        addr_ok;
  logic [15:0] dout;
  logic        data_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_read;
  logic [15:0] sdram_din;

  logic [16:0] addr_b;
  logic        addr_ok_b;
  logic [15:0] dout_b;
  logic        data_ok_b;
  logic [21:0] sdram_addr_b;
  logic        sdram_req_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jtdd_scr_romrq #(.OFFSET(22'h0), .AW(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .addr_ok    (addr_ok),
    .dout       (dout),
    .data_ok    (data_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_read  (data_read),
    .sdram_din  (sdram_din)
  );

  jtdd_scr_romrq #(.OFFSET(22'h3F0000), .AW(17)) dut_ofs (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr_b),
    .addr_ok    (addr_ok_b),
    .dout       (dout_b),
    .data_ok    (data_ok_b),
    .sdram_addr (sdram_addr_b),
    .sdram_req  (sdram_req_b),
    .sdram_ack  (1'b0),
    .data_read  (1'b0),
    .sdram_din  (16'h0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; addr = '0; addr_ok = 1'b0;
    sdram_ack = 1'b0; data_read = 1'b0; sdram_din = 16'h0;
    addr_b = 17'h1FFFF; addr_ok_b = 1'b0;
    step(); step();
    check("rst_data_ok", {31'd0, data_ok}, 32'd0);
    check("rst_dout",    {16'd0, dout},    32'd0);
    check("rst_req",     {31'd0, sdram_req}, 32'd0);

    // first fetch at 0x10, ack two cycles after req, data three after ack
    rst = 1'b0; addr = 17'h00010; addr_ok = 1'b1; addr_ok_b = 1'b1;
    #1 check("miss_data_ok", {31'd0, data_ok}, 32'd0);
    step();
    check("req_up",    {31'd0, sdram_req}, 32'd1);
    check("req_addr",  {10'd0, sdram_addr}, 32'h000010);
    check("wrap_addr", {10'd0, sdram_addr_b}, 32'h00FFFF);
    check("wrap_req",  {31'd0, sdram_req_b}, 32'd1);
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("req_drop", {31'd0, sdram_req}, 32'd0);
    step(); step();
    data_read = 1'b1; sdram_din = 16'hA55A;
    #1 check("wait_data_ok", {31'd0, data_ok}, 32'd0);
    step();
    data_read = 1'b0; sdram_din = 16'h0;
    #1 check("fill_data_ok", {31'd0, data_ok}, 32'd1);
    check("fill_dout", {16'd0, dout}, 32'h0000A55A);
    step(); step(); step();
    check("hit_no_req", {31'd0, sdram_req}, 32'd0);

    // addr changes 0x10 -> 0x20 while waiting for data
    rst = 1'b1; step(); rst = 1'b0;
    addr = 17'h00010;
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; addr = 17'h00020;
    #1 check("chg_wait_ok", {31'd0, data_ok}, 32'd0);
    step();
    data_read = 1'b1; sdram_din = 16'h1234;
    step();
    data_read = 1'b0;
    #1 check("chg_miss_ok", {31'd0, data_ok}, 32'd0);
    check("chg_idle_req", {31'd0, sdram_req}, 32'd0);
    step();
    check("chg_req2", {31'd0, sdram_req}, 32'd1);
    check("chg_addr2", {10'd0, sdram_addr}, 32'h000020);
    addr = 17'h00010;
    #1 check("old_line_ok", {31'd0, data_ok}, 32'd1);
    check("old_line_dout", {16'd0, dout}, 32'h00001234);

    // ack and data_read in the same cycle
    step();
    addr = 17'h00020; sdram_ack = 1'b1; data_read = 1'b1; sdram_din = 16'hBEEF;
    step();
    sdram_ack = 1'b0; data_read = 1'b0; sdram_din = 16'h0;
    #1 check("same_data_ok", {31'd0, data_ok}, 32'd1);
    check("same_dout", {16'd0, dout}, 32'h0000BEEF);
    check("same_req", {31'd0, sdram_req}, 32'd0);
    step();
    check("same_idle_req", {31'd0, sdram_req}, 32'd0);

`ifdef JTDD_SCR_DUALLINE_EN
    for (int i = 0; i < 4; i++) begin
      addr = (i % 2 == 0) ? 17'h00010 : 17'h00020;
      #1 check("dual_hit", {31'd0, data_ok}, 32'd1);
      check("dual_dout", {16'd0, dout}, (i % 2 == 0) ? 32'h00001234 : 32'h0000BEEF);
      step();
      check("dual_no_req", {31'd0, sdram_req}, 32'd0);
    end
`else
    addr = 17'h00010;
    #1 check("single_evict", {31'd0, data_ok}, 32'd0);
`endif

    // reset mid-fetch, later data_read ignored
    rst = 1'b1; step(); rst = 1'b0;
    addr = 17'h00040; addr_ok = 1'b1;
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; addr_ok = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    data_read = 1'b1; sdram_din = 16'hFFFF;
    step();
    data_read = 1'b0;
    check("rstmid_req", {31'd0, sdram_req}, 32'd0);
    addr = 17'h00000; addr_ok = 1'b1;
    #1 check("rstmid_valid", {31'd0, data_ok}, 32'd0);
    check("rstmid_dout", {16'd0, dout}, 32'd0);
    addr_ok = 1'b0;
    step();
    check("rstmid_idle", {31'd0, sdram_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
